// File: rtl/vram_pkg.sv
// vram_pkg: shared types and helpers for the dual-port video RAM.
//   size_e       access size encoding on the request ports
//   clr_state_e  clear engine states
//   BM_*         byte-write rule selectors for the BYTE_MODE parameter
//   calc_be()    byte-enable generation from size, low address bits and rule
package vram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic {
        CS_IDLE  = 1'b0,
        CS_CLEAR = 1'b1
    } clr_state_e;

    localparam int BM_NORMAL      = 0;
    localparam int BM_DUP_HALF    = 1;
    localparam int BM_IGNORE_BYTE = 2;

    // Reserved size 3 falls into the word branch.
    function automatic logic [3:0] calc_be(input logic [1:0] size,
                                           input logic [1:0] lo,
                                           input int         byte_mode);
        logic [3:0] be;
        case (size_e'(size))
            SZ_BYTE: begin
                if (byte_mode == BM_DUP_HALF)
                    be = lo[1] ? 4'b1100 : 4'b0011;
                else if (byte_mode == BM_IGNORE_BYTE)
                    be = 4'b0000;
                else
                    be = 4'b0001 << lo;
            end
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/vram_port_lane.sv
// vram_port_lane: per-port lane steering.
//   size_i, addr_lo_i, wdata_i   write-side request fields
//   be_o, wdata_o                byte enables and lane-replicated write data
//   rd_size_i, rd_addr_lo_i      registered size/offset of the last read
//   rd_word_i                    registered array word of the last read
//   rdata_o                      addressed unit replicated across all lanes
module vram_port_lane
    import vram_pkg::*;
#(
    parameter int BYTE_MODE = BM_NORMAL
) (
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  rd_size_i,
    input  logic [1:0]  rd_addr_lo_i,
    input  logic [31:0] rd_word_i,
    output logic [31:0] rdata_o
);

    always_comb begin
        be_o = calc_be(size_i, addr_lo_i, BYTE_MODE);
        case (size_e'(size_i))
            SZ_BYTE: wdata_o = {4{wdata_i[7:0]}};
            SZ_HALF: wdata_o = {2{wdata_i[15:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

    always_comb begin
        case (size_e'(rd_size_i))
            SZ_BYTE: rdata_o = {4{rd_word_i[{rd_addr_lo_i, 3'b000} +: 8]}};
            SZ_HALF: rdata_o = rd_addr_lo_i[1] ? {2{rd_word_i[31:16]}}
                                               : {2{rd_word_i[15:0]}};
            default: rdata_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/vram_dp.sv
// vram_dp: true dual-port byte-enabled video RAM with a built-in clear engine.
//   clk_i, rst_i                 clock, synchronous active-high reset
//   {a,b}_req_i/_we_i/_size_i    per-port request, write flag, access size
//   {a,b}_addr_i/_wdata_i        byte address and low-lane write data
//   {a,b}_rdata_o/_rvalid_o      registered read data and valid
//   clr_start_i, clr_busy_o      clear engine start pulse and busy flag
//   collision_o                  overlapping dual write seen last cycle
//
// Clear engine states:
//   state    | meaning
//   CS_IDLE  | ports serviced normally
//   CS_CLEAR | zeroing words cnt and cnt+DEPTH/2 each cycle, ports dropped
module vram_dp
    import vram_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int AW          = $clog2(DEPTH_WORDS) + 2,
    parameter int BYTE_MODE   = BM_NORMAL
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          a_req_i,
    input  logic          a_we_i,
    input  logic [1:0]    a_size_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [31:0]   a_wdata_i,
    output logic [31:0]   a_rdata_o,
    output logic          a_rvalid_o,
    input  logic          b_req_i,
    input  logic          b_we_i,
    input  logic [1:0]    b_size_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [31:0]   b_wdata_i,
    output logic [31:0]   b_rdata_o,
    output logic          b_rvalid_o,
    input  logic          clr_start_i,
    output logic          clr_busy_o,
    output logic          collision_o
);

    localparam int IW = AW - 2;
    localparam int CW = IW - 1;

    logic [31:0]   mem [DEPTH_WORDS];

    clr_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          collision_q, collision_d;

    logic [3:0]    a_be, b_be;
    logic [31:0]   a_wd, b_wd;
    logic [IW-1:0] a_idx, b_idx;
    logic          a_wr, b_wr, a_rd, b_rd;

    logic [31:0]   a_rword_q, b_rword_q;
    logic [1:0]    a_rsize_q, b_rsize_q, a_rlo_q, b_rlo_q;
    logic          a_rvalid_q, b_rvalid_q;

    vram_port_lane #(.BYTE_MODE(BYTE_MODE)) u_lane_a (
        .size_i       (a_size_i),
        .addr_lo_i    (a_addr_i[1:0]),
        .wdata_i      (a_wdata_i),
        .be_o         (a_be),
        .wdata_o      (a_wd),
        .rd_size_i    (a_rsize_q),
        .rd_addr_lo_i (a_rlo_q),
        .rd_word_i    (a_rword_q),
        .rdata_o      (a_rdata_o)
    );

    vram_port_lane #(.BYTE_MODE(BYTE_MODE)) u_lane_b (
        .size_i       (b_size_i),
        .addr_lo_i    (b_addr_i[1:0]),
        .wdata_i      (b_wdata_i),
        .be_o         (b_be),
        .wdata_o      (b_wd),
        .rd_size_i    (b_rsize_q),
        .rd_addr_lo_i (b_rlo_q),
        .rd_word_i    (b_rword_q),
        .rdata_o      (b_rdata_o)
    );

    assign clr_busy_o  = (state_q == CS_CLEAR);
    assign a_idx       = a_addr_i[AW-1:2];
    assign b_idx       = b_addr_i[AW-1:2];
    // An all-zero enable (dropped byte write) makes the request a no-op.
    assign a_wr        = a_req_i & ~clr_busy_o & a_we_i & (|a_be);
    assign b_wr        = b_req_i & ~clr_busy_o & b_we_i & (|b_be);
    assign a_rd        = a_req_i & ~clr_busy_o & ~a_we_i;
    assign b_rd        = b_req_i & ~clr_busy_o & ~b_we_i;
    assign collision_d = a_wr & b_wr & (a_idx == b_idx) & (|(a_be & b_be));

    assign a_rvalid_o  = a_rvalid_q;
    assign b_rvalid_o  = b_rvalid_q;
    assign collision_o = collision_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CS_IDLE: begin
                if (clr_start_i) begin
                    state_d = CS_CLEAR;
                    cnt_d   = '0;
                end
            end
            CS_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {CW{1'b1}})
                    state_d = CS_IDLE;
            end
            default: state_d = CS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= CS_IDLE;
            cnt_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            collision_q <= collision_d;
        end
    end

    // Array has no reset. Clear writes are suppressed under rst so an abort
    // leaves exactly the words already zeroed. Port B is applied before
    // port A so A's lanes win on overlap.
    always_ff @(posedge clk_i) begin
        if (clr_busy_o && !rst_i) begin
            mem[{1'b0, cnt_q}] <= '0;
            mem[{1'b1, cnt_q}] <= '0;
        end
        for (int i = 0; i < 4; i++) begin
            if (b_wr && b_be[i]) mem[b_idx][8*i +: 8] <= b_wd[8*i +: 8];
            if (a_wr && a_be[i]) mem[a_idx][8*i +: 8] <= a_wd[8*i +: 8];
        end
    end

    // Read word and its size/offset are held while idle so rdata keeps
    // its last value; reads see pre-write contents of the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rword_q  <= '0;
            b_rword_q  <= '0;
            a_rsize_q  <= '0;
            b_rsize_q  <= '0;
            a_rlo_q    <= '0;
            b_rlo_q    <= '0;
        end else begin
            a_rvalid_q <= a_rd;
            b_rvalid_q <= b_rd;
            if (a_rd) begin
                a_rword_q <= mem[a_idx];
                a_rsize_q <= a_size_i;
                a_rlo_q   <= a_addr_i[1:0];
            end
            if (b_rd) begin
                b_rword_q <= mem[b_idx];
                b_rsize_q <= b_size_i;
                b_rlo_q   <= b_addr_i[1:0];
            end
        end
    end

endmodule

// File: tb/tb_vram_dp.sv
module tb_vram_dp;
    import vram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we, clr_start;
    logic [1:0]  a_size, b_size;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [2:0]  sel;

    logic [31:0] ard [3];
    logic [31:0] brd [3];
    logic        arv [3];
    logic        brv [3];
    logic        busy [3];
    logic        col [3];

    typedef struct {
        int          d;
        bit          p;
        logic [31:0] v;
    } sb_t;
    sb_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cur     = 0;

    always #5 clk = ~clk;

    // dut 0: 64 words normal; dut 1: 16 words dup-half; dut 2: 16 words ignore-byte
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int DW  = (k == 0) ? 64 : 16;
        localparam int AWK = $clog2(DW) + 2;
        vram_dp #(.DEPTH_WORDS(DW), .AW(AWK), .BYTE_MODE(k)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .a_req_i     (a_req & sel[k]),
            .a_we_i      (a_we),
            .a_size_i    (a_size),
            .a_addr_i    (a_addr[AWK-1:0]),
            .a_wdata_i   (a_wdata),
            .a_rdata_o   (ard[k]),
            .a_rvalid_o  (arv[k]),
            .b_req_i     (b_req & sel[k]),
            .b_we_i      (b_we),
            .b_size_i    (b_size),
            .b_addr_i    (b_addr[AWK-1:0]),
            .b_wdata_i   (b_wdata),
            .b_rdata_o   (brd[k]),
            .b_rvalid_o  (brv[k]),
            .clr_start_i (clr_start & sel[k]),
            .clr_busy_o  (busy[k]),
            .collision_o (col[k])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic use_dut(input int d);
        cur = d;
        sel = 3'b001 << d;
    endtask

    task automatic wr_a(input logic [1:0] sz, input logic [7:0] ad, input logic [31:0] wd);
        a_req = 1'b1; a_we = 1'b1; a_size = sz; a_addr = ad; a_wdata = wd;
    endtask

    task automatic wr_b(input logic [1:0] sz, input logic [7:0] ad, input logic [31:0] wd);
        b_req = 1'b1; b_we = 1'b1; b_size = sz; b_addr = ad; b_wdata = wd;
    endtask

    task automatic rd_a(input logic [1:0] sz, input logic [7:0] ad, input logic [31:0] exp);
        a_req = 1'b1; a_we = 1'b0; a_size = sz; a_addr = ad;
        sb_q.push_back('{d: cur, p: 1'b0, v: exp});
    endtask

    task automatic rd_b(input logic [1:0] sz, input logic [7:0] ad, input logic [31:0] exp);
        b_req = 1'b1; b_we = 1'b0; b_size = sz; b_addr = ad;
        sb_q.push_back('{d: cur, p: 1'b1, v: exp});
    endtask

    // Advance one cycle, drop request strobes, then retire every read
    // issued in the cycle just finished.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0; clr_start = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.p == 1'b0) begin
                chk($sformatf("d%0d_a_rvalid", e.d), 32'(arv[e.d]), 32'd1);
                chk($sformatf("d%0d_a_rdata", e.d), ard[e.d], e.v);
            end else begin
                chk($sformatf("d%0d_b_rvalid", e.d), 32'(brv[e.d]), 32'd1);
                chk($sformatf("d%0d_b_rdata", e.d), brd[e.d], e.v);
            end
        end
    endtask

    task automatic chk_reset_outputs(input int d, input string tag);
        chk({tag, "_a_rdata"}, ard[d], 32'h0);
        chk({tag, "_b_rdata"}, brd[d], 32'h0);
        chk({tag, "_a_rvalid"}, 32'(arv[d]), 32'd0);
        chk({tag, "_b_rvalid"}, 32'(brv[d]), 32'd0);
        chk({tag, "_busy"}, 32'(busy[d]), 32'd0);
        chk({tag, "_collision"}, 32'(col[d]), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; sel = 3'b000; clr_start = 1'b0;
        a_req = 0; a_we = 0; a_size = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_size = 0; b_addr = 0; b_wdata = 0;
        tick(); tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) chk_reset_outputs(d, $sformatf("rst_d%0d", d));

        // ---- dut 0: basic access, latency, hold ----
        use_dut(0);
        wr_a(SZ_WORD, 8'h10, 32'hDEADBEEF); tick();
        chk("write_no_rvalid", 32'(arv[0]), 32'd0);
        rd_b(SZ_BYTE, 8'h12, 32'hADADADAD); tick();
        tick();
        chk("rvalid_one_cycle", 32'(brv[0]), 32'd0);
        chk("rdata_hold", brd[0], 32'hADADADAD);
        rd_a(SZ_HALF, 8'h12, 32'hDEADDEAD);
        rd_b(SZ_WORD, 8'h10, 32'hDEADBEEF); tick();
        rd_a(SZ_RSVD, 8'h13, 32'hDEADBEEF);
        rd_b(SZ_BYTE, 8'h11, 32'hBEBEBEBE); tick();
        rd_a(SZ_HALF, 8'h11, 32'hBEEFBEEF); tick();

        // overlapping dual write: A wins on lanes 1:0
        wr_a(SZ_HALF, 8'h40, 32'h00001111);
        wr_b(SZ_WORD, 8'h40, 32'h22334455); tick();
        chk("collision_pulse", 32'(col[0]), 32'd1);
        rd_a(SZ_WORD, 8'h40, 32'h22331111); tick();
        chk("collision_drop", 32'(col[0]), 32'd0);

        // non-overlapping dual write into one word
        wr_a(SZ_WORD, 8'h50, 32'h0); tick();
        wr_a(SZ_BYTE, 8'h50, 32'h000000AA);
        wr_b(SZ_BYTE, 8'h51, 32'h000000BB); tick();
        chk("no_collision", 32'(col[0]), 32'd0);
        rd_b(SZ_WORD, 8'h50, 32'h0000BBAA); tick();

        // read-old-data then new data
        wr_a(SZ_WORD, 8'h80, 32'h11111111); tick();
        wr_a(SZ_WORD, 8'h80, 32'h99999999);
        rd_b(SZ_WORD, 8'h80, 32'h11111111); tick();
        rd_b(SZ_WORD, 8'h80, 32'h99999999); tick();

        // ---- dut 1: byte duplicated into halfword ----
        use_dut(1);
        wr_a(SZ_WORD, 8'h20, 32'h0); tick();
        wr_a(SZ_BYTE, 8'h21, 32'hFFFFFF5A); tick();
        rd_a(SZ_WORD, 8'h20, 32'h00005A5A); tick();

        // ---- dut 2: byte writes dropped ----
        use_dut(2);
        wr_a(SZ_WORD, 8'h20, 32'hCAFEF00D); tick();
        wr_a(SZ_BYTE, 8'h21, 32'h0000005A);
        wr_b(SZ_BYTE, 8'h21, 32'h000000A5); tick();
        chk("ignored_byte_no_collision", 32'(col[2]), 32'd0);
        rd_b(SZ_WORD, 8'h20, 32'hCAFEF00D); tick();
        wr_a(SZ_HALF, 8'h22, 32'h00001234); tick();
        rd_a(SZ_WORD, 8'h20, 32'h1234F00D); tick();

        // ---- dut 1: full clear ----
        use_dut(1);
        for (int i = 0; i < 16; i++) begin
            wr_a(SZ_WORD, 8'(i * 4), 32'hA5000000 | 32'(i) | 32'h100); tick();
        end
        rd_a(SZ_WORD, 8'h0C, 32'hA5000103);
        clr_start = 1'b1; tick();
        chk("clr_busy_rise", 32'(busy[1]), 32'd1);
        n = 0;
        while (busy[1] && n < 20) begin
            wr_a(SZ_WORD, 8'h14, 32'hFFFFFFFF);
            b_req = 1'b1; b_we = 1'b0; b_size = SZ_WORD; b_addr = 8'h00;
            if (n == 3) clr_start = 1'b1;
            tick();
            chk("clr_drop_rvalid", 32'(brv[1]), 32'd0);
            n++;
        end
        chk("clr_busy_cycles", 32'(n), 32'd8);
        for (int i = 0; i < 16; i++) begin
            rd_a(SZ_WORD, 8'(i * 4), 32'h0); tick();
        end

        // ---- dut 1: reset aborts clear at counter 3 ----
        for (int i = 0; i < 16; i++) begin
            wr_a(SZ_WORD, 8'(i * 4), 32'hB0000000 | 32'(i)); tick();
        end
        rd_b(SZ_WORD, 8'h1C, 32'hB0000007);
        clr_start = 1'b1; tick();
        tick(); tick(); tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk_reset_outputs(1, "rst_mid_clear");
        for (int i = 0; i < 16; i++) begin
            rd_a(SZ_WORD, 8'(i * 4),
                 ((i % 8) < 3) ? 32'h0 : (32'hB0000000 | 32'(i))); tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_dp.md
# vram_dp

Parametrised true dual-port video RAM for the GBA memory subsystem, one clock domain. Both ports accept 8/16/32-bit accesses through per-byte write enables and return registered, lane-aligned read data. A configurable byte-write rule covers GBA VRAM semantics: normal, duplicate into the halfword, or ignore. A built-in clear engine zeroes the whole array without CPU involvement.

## Interface
- DEPTH_WORDS, 16384: number of 32-bit words; power of two, ≥ 4.
- AW, $clog2(DEPTH_WORDS)+2: byte-address width.
- BYTE_MODE, 0: byte-write rule. 0 = normal byte write; 1 = byte replicated into both lanes of the addressed halfword (BG VRAM); 2 = byte writes dropped (OBJ VRAM).
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- a_req / b_req  in  1  access request, one per cycle.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_size / b_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- a_addr / b_addr  in  AW  byte address; ignored low bits are forced to alignment (half: bit0; word: bits1:0).
- a_wdata / b_wdata  in  32  write data, taken from the low lanes (byte = [7:0], half = [15:0]).
- a_rdata / b_rdata  out  32  read data, addressed unit replicated across all lanes.
- a_rvalid / b_rvalid  out  1  read data valid.
- clr_start  in  1  pulse that starts a full-array clear.
- clr_busy  out  1  clear in progress.
- collision  out  1  one-cycle pulse when both ports wrote an overlapping byte of the same word.

## Operation
- Word index = addr[AW-1:2]. Byte enables are derived from size and addr[1:0]: byte = 1 lane; half = lanes {1,0} or {3,2}; word = all four. Write data is replicated to all lanes before masking.
- BYTE_MODE 1, byte write: enables widen to the full halfword containing the byte, and both bytes get wdata[7:0]. BYTE_MODE 2, byte write: no enables, no collision contribution, request otherwise ignored.
- Reads are read-old-data. A read on one port in the same cycle as a write to the same word on either port returns the pre-write contents.
- Dual write to the same word: non-overlapping lanes from both ports are written. Where lanes overlap, port A wins, and collision pulses on the following cycle.
- Writes produce no rvalid.
- Clear engine states: IDLE → CLEAR → IDLE.
  - clr_start in IDLE enters CLEAR on the next cycle, with counter = 0.
  - Each CLEAR cycle writes zero to words counter and counter + DEPTH_WORDS/2, then increments the counter.
  - Exit to IDLE after counter reaches DEPTH_WORDS/2 − 1.
  - clr_start during CLEAR is ignored.
  - While clr_busy = 1, all port requests are dropped: no write, rvalid stays 0.
- rst aborts a clear, returns the engine to IDLE, and clears rvalid, rdata and collision. Array contents are not reset; a partial clear leaves partially zeroed contents.

## Timing
- Read latency is one cycle. A request in cycle N gives rvalid = 1 and rdata in cycle N+1 only, then rvalid drops unless the port issues another read. rdata holds its last value when rvalid = 0.
- Full throughput: a new request is accepted on both ports every cycle, with no back-pressure.
- A write in cycle N is visible to a read issued in cycle N+1 or later.
- collision asserts in cycle N+1 for an overlapping dual write in cycle N.
- clr_busy asserts in the cycle after clr_start and deasserts after DEPTH_WORDS/2 CLEAR cycles. A request issued on the clr_start cycle itself is still serviced.
- Reset values: a_rdata = b_rdata = 0, a_rvalid = b_rvalid = 0, clr_busy = 0, collision = 0.

## Structure
- Shared package vram_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the BYTE_MODE constants (BM_NORMAL, BM_DUP_HALF, BM_IGNORE_BYTE);
  - the function computing byte enables from size, low address bits and BYTE_MODE.
- One sub-module, vram_port_lane, instantiated per port. It does enable/data steering on the write side and lane replication of the read word into rdata.
- Array, collision merge and clear FSM live in vram_dp. The array is inferred as a byte-enabled dual-port memory.

## Test plan
- Word write A addr 0x0010 = 0xDEADBEEF, then byte read B at 0x0012 → b_rdata = 0xADADADAD, b_rvalid high exactly one cycle later.
- BYTE_MODE 1: byte write 0x5A at 0x0021 → word 8 reads 0x00005A5A; BYTE_MODE 2: same write → word 8 unchanged.
- Same cycle: A half write 0x1111 at 0x0040, B word write 0x22334455 at 0x0040 → word reads 0x22331111, collision = 1 the next cycle.
- A word write to 0x0080 with B read of 0x0080 in the same cycle → B returns old data; B read the next cycle returns new data.
- DEPTH_WORDS = 16 with all words preloaded nonzero, then clr_start → clr_busy high 8 cycles, requests dropped, all 16 words read 0 afterwards.
- rst asserted mid-clear at counter = 3 → clr_busy = 0 next cycle, words 0–2 and 8–10 are zero and the rest keep their preloaded values; outputs match reset values.
